// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding an 8N1 UART transmitter.
// A granted byte is latched on the grant edge and shifted out LSB first on a registered tx line.
module uart_tx_arbiter #(
  parameter int BAUD_DIV = 326
) (
  input  logic       SystemClk,
  input  logic       Reset,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       gnt0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       gnt1,
  output logic       tx,
  output logic       busy,
  output logic       owner
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [8:0] BAUD_LAST = 9'(BAUD_DIV - 1);

  state_t      state_q, state_d;
  logic [8:0]  baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        owner_q, owner_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        tx_q, tx_d;
  logic        bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    owner_d = owner_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    tx_d    = 1'b1;

    unique case (state_q)
      IDLE: begin
        baud_d = 9'd0;
        // On a tie, requester 0 wins only when requester 1 was served last.
        if (req0 && (!req1 || owner_q)) begin
          gnt0_d  = 1'b1;
          shift_d = data0;
          owner_d = 1'b0;
          bit_d   = 3'd0;
          state_d = START;
        end else if (req1) begin
          gnt1_d  = 1'b1;
          shift_d = data1;
          owner_d = 1'b1;
          bit_d   = 3'd0;
          state_d = START;
        end
      end
      START: begin
        baud_d = bit_end ? 9'd0 : baud_q + 9'd1;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        baud_d = bit_end ? 9'd0 : baud_q + 9'd1;
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        baud_d = bit_end ? 9'd0 : baud_q + 9'd1;
        if (bit_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // tx is derived from the next state so the registered line changes on the same edge as the state.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge SystemClk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      baud_q  <= 9'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      owner_q <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      owner_q <= owner_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      tx_q    <= tx_d;
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign tx    = tx_q;
  assign busy  = (state_q != IDLE);
  assign owner = owner_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter at BAUD_DIV=4 (40-cycle frames).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_uart_tx_arbiter;

  logic       SystemClk;
  logic       Reset;
  logic       req0;
  logic [7:0] data0;
  logic       gnt0;
  logic       req1;
  logic [7:0] data1;
  logic       gnt1;
  logic       tx;
  logic       busy;
  logic       owner;

  int assertion_cnt = 0;
  int fail_cnt      = 0;

  uart_tx_arbiter #(.BAUD_DIV(4)) dut (
    .SystemClk(SystemClk),
    .Reset    (Reset),
    .req0     (req0),
    .data0    (data0),
    .gnt0     (gnt0),
    .req1     (req1),
    .data1    (data1),
    .gnt1     (gnt1),
    .tx       (tx),
    .busy     (busy),
    .owner    (owner)
  );

  initial SystemClk = 1'b0;
  always #5 SystemClk = ~SystemClk;

  task automatic tick();
    @(negedge SystemClk);
  endtask

  task automatic applyStimulus(input logic r0, input logic [7:0] d0,
                               input logic r1, input logic [7:0] d1);
    req0  = r0;
    data0 = d0;
    req1  = r1;
    data1 = d1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertion_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the falling edge of the first frame cycle; returns at the falling edge of the idle cycle.
  task automatic checkFrame(input logic [7:0] b, input int req1_at, input logic [7:0] d1);
    logic exp_tx;
    for (int k = 0; k < 40; k++) begin
      if (k == req1_at) begin
        req1  = 1'b1;
        data1 = d1;
      end
      if (k < 4)       exp_tx = 1'b0;
      else if (k < 36) exp_tx = b[(k - 4) / 4];
      else             exp_tx = 1'b1;
      checkOutput($sformatf("tx_k%0d", k), {31'd0, tx}, {31'd0, exp_tx});
      checkOutput($sformatf("busy_k%0d", k), {31'd0, busy}, 32'd1);
      if (k > 0) begin
        checkOutput($sformatf("gnt0_k%0d", k), {31'd0, gnt0}, 32'd0);
        checkOutput($sformatf("gnt1_k%0d", k), {31'd0, gnt1}, 32'd0);
      end
      tick();
    end
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("idle_tx", {31'd0, tx}, 32'd1);
    checkOutput("idle_gnt0", {31'd0, gnt0}, 32'd0);
    checkOutput("idle_gnt1", {31'd0, gnt1}, 32'd0);
  endtask

  task automatic checkGrant(input string tag, input logic g0, input logic g1, input logic own);
    checkOutput({tag, "_gnt0"}, {31'd0, gnt0}, {31'd0, g0});
    checkOutput({tag, "_gnt1"}, {31'd0, gnt1}, {31'd0, g1});
    checkOutput({tag, "_owner"}, {31'd0, owner}, {31'd0, own});
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic pulseReset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_tx", {31'd0, tx}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_gnt0", {31'd0, gnt0}, 32'd0);
    checkOutput("rst_gnt1", {31'd0, gnt1}, 32'd0);
    checkOutput("rst_owner", {31'd0, owner}, 32'd1);
    tick();
    Reset = 1'b0;

    $display("[TB] single send 0xA5");
    applyStimulus(1'b1, 8'hA5, 1'b0, 8'h00);
    tick();
    checkGrant("single", 1'b1, 1'b0, 1'b0);
    req0 = 1'b0;
    checkFrame(8'hA5, -1, 8'h00);
    tick();
    checkOutput("single_quiet_busy", {31'd0, busy}, 32'd0);
    checkOutput("single_owner_kept", {31'd0, owner}, 32'd0);

    $display("[TB] tie after reset");
    pulseReset();
    applyStimulus(1'b1, 8'h11, 1'b1, 8'h22);
    tick();
    checkGrant("tie_first", 1'b1, 1'b0, 1'b0);
    checkFrame(8'h11, -1, 8'h22);
    tick();
    checkGrant("tie_second", 1'b0, 1'b1, 1'b1);
    checkFrame(8'h22, -1, 8'h22);
    tick();
    checkGrant("tie_third", 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h11, 1'b0, 8'h22);
    checkFrame(8'h11, -1, 8'h00);

    $display("[TB] pending request and data change");
    tick();
    applyStimulus(1'b1, 8'h0F, 1'b0, 8'h00);
    tick();
    checkGrant("chg", 1'b1, 1'b0, 1'b0);
    req0  = 1'b0;
    data0 = 8'hF0;
    checkFrame(8'h0F, 10, 8'h3C);
    tick();
    checkGrant("pend", 1'b0, 1'b1, 1'b1);
    req1 = 1'b0;
    checkFrame(8'h3C, -1, 8'h00);

    $display("[TB] reset mid-frame");
    tick();
    applyStimulus(1'b1, 8'h00, 1'b0, 8'h00);
    tick();
    checkGrant("abort", 1'b1, 1'b0, 1'b0);
    req0 = 1'b0;
    for (int k = 0; k < 17; k++) tick();
    checkOutput("abort_bit3_tx", {31'd0, tx}, 32'd0);
    checkOutput("abort_bit3_busy", {31'd0, busy}, 32'd1);
    Reset = 1'b1;
    #1;
    checkOutput("abort_async_tx", {31'd0, tx}, 32'd1);
    checkOutput("abort_async_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_async_owner", {31'd0, owner}, 32'd1);
    #2;
    Reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      checkOutput($sformatf("abort_idle_tx_%0d", k), {31'd0, tx}, 32'd1);
      checkOutput($sformatf("abort_idle_busy_%0d", k), {31'd0, busy}, 32'd0);
      checkOutput($sformatf("abort_idle_gnt0_%0d", k), {31'd0, gnt0}, 32'd0);
    end

    $display("[TB] back-to-back 0x55");
    applyStimulus(1'b1, 8'h55, 1'b0, 8'h00);
    tick();
    checkGrant("b2b_first", 1'b1, 1'b0, 1'b0);
    checkFrame(8'h55, -1, 8'h00);
    tick();
    checkGrant("b2b_second", 1'b1, 1'b0, 1'b0);
    req0 = 1'b0;
    checkFrame(8'h55, -1, 8'h00);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("b2b_done_busy_%0d", k), {31'd0, busy}, 32'd0);
      checkOutput($sformatf("b2b_done_gnt0_%0d", k), {31'd0, gnt0}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertion_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter BAUD_DIV, default 326, giving SystemClk cycles per serial bit (legal range 2..511).
REQ-002 Port SystemClk SHALL be input, width 1: the single clock; all state updates on its rising edge.
REQ-003 Port Reset SHALL be input, width 1: asynchronous, active-high reset.
REQ-004 Port req0 SHALL be input, width 1: requester 0 has a byte to send (level, held until gnt0).
REQ-005 Port data0 SHALL be input, width 8: requester 0 byte.
REQ-006 Port gnt0 SHALL be output, width 1: one-cycle pulse, data0 captured.
REQ-007 Port req1 SHALL be input, width 1: requester 1 has a byte to send (level, held until gnt1).
REQ-008 Port data1 SHALL be input, width 8: requester 1 byte.
REQ-009 Port gnt1 SHALL be output, width 1: one-cycle pulse, data1 captured.
REQ-010 Port tx SHALL be output, width 1: serial line, 8N1, idle high.
REQ-011 Port busy SHALL be output, width 1: high while a frame is in progress.
REQ-012 Port owner SHALL be output, width 1: index of the requester whose frame is in progress or was sent last.

Function
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-014 In IDLE with exactly one req high, that requester SHALL be granted on the next edge.
REQ-015 In IDLE with both req high, the grant SHALL go to the requester not equal to owner (round-robin).
REQ-016 On the grant edge: gnt pulses high for exactly one cycle, the granted data is latched into the shift register, owner updates, state goes to START, and the bit counter clears to 0.
REQ-017 Data inputs SHALL be sampled only on the grant edge; later changes SHALL NOT affect the frame.
REQ-018 The baud counter SHALL count 0..BAUD_DIV-1 only outside IDLE, wrapping to 0; each wrap ends one bit period.
REQ-019 In START, tx SHALL be 0 for BAUD_DIV cycles, starting the cycle after the grant edge.
REQ-020 In DATA, tx SHALL present data bits LSB first, BAUD_DIV cycles each; a 3-bit index counts 0..7, and after bit 7 the state goes to STOP.
REQ-021 In STOP, tx SHALL be 1 for BAUD_DIV cycles, then the state returns to IDLE.
REQ-022 A frame SHALL occupy exactly 10*BAUD_DIV cycles of busy high, then at least one IDLE cycle before the next grant.
REQ-023 tx SHALL be registered (no combinational glitch) and SHALL be 1 in IDLE.
REQ-024 busy SHALL be 0 in IDLE and 1 in START, DATA and STOP.
REQ-025 Requests arriving outside IDLE SHALL be held pending, with no gnt until IDLE.
REQ-026 A requester keeping req high after its gnt SHALL be treated as a new request; round-robin still applies.
REQ-027 gnt0 and gnt1 SHALL never be high in the same cycle.

Reset
REQ-028 While Reset is high, regardless of the clock:
- state = IDLE
- tx = 1, busy = 0, gnt0 = gnt1 = 0
- owner = 1, so requester 0 wins the first tie
- baud counter, bit index and shift register = 0
REQ-029 Reset mid-frame SHALL abort the frame immediately (tx high asynchronously); the aborted requester SHALL NOT be re-granted automatically.
REQ-030 After Reset deasserts, the first grant SHALL occur no earlier than the first rising edge with Reset low.

Verification (BAUD_DIV=4)
REQ-031 Single send: req0=1, data0=0xA5 -> gnt0 pulse; then on tx: 0 for 4 cycles; bits 1,0,1,0,0,1,0,1 at 4 cycles each; 1 for 4 cycles; busy high for 40 cycles; owner=0.
REQ-032 Tie after reset: req0=req1=1 together -> gnt0 first (0x11 frame); after one IDLE cycle gnt1 (0x22 frame); then gnt0 again if both are still held.
REQ-033 Pending request: req1 raised during requester 0's DATA state -> no gnt1 until IDLE; gnt1 asserted on the first IDLE edge; first frame bits unaffected.
REQ-034 Data change: data0 changed from 0x0F to 0xF0 one cycle after gnt0 -> tx still serialises 0x0F.
REQ-035 Reset mid-frame: Reset pulsed in DATA bit 3 -> tx=1, busy=0 at once; with req0 low, the line stays idle.
REQ-036 Back-to-back: req0 held high with 0x55 -> consecutive 40-cycle frames separated by exactly 1 IDLE cycle; gnt0 never two cycles in a row.
